// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM states,
// EX-stage resolution codes and the default redirect mask.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH      = 2'd1,
        MEM_WAIT   = 2'd2,
        FETCH_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] BJ_NONE = 3'd0;
    localparam logic [2:0] BJ_BEQ  = 3'd1;
    localparam logic [2:0] BJ_J    = 3'd2;
    localparam logic [2:0] BJ_JR   = 3'd3;

    // Codes 1..3 (BEQ taken, J, JR) redirect the PC; all others fall through.
    localparam logic [7:0] BRANCH_MASK_DEF = 8'b0000_1110;

endpackage

// File: rtl/pipe_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a
// same-cycle increment and the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges redirect, load-use,
// fetch-wait and memory-busy into per-stage enables/flushes and the PC mux select.
module pipe_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter logic [7:0]  BRANCH_MASK = BRANCH_MASK_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       branch_jump,
    input  logic [31:0]      redirect_pc,
    input  logic             load_use,
    input  logic             imem_ready,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned FCNT_W = $clog2(FLUSH_DEPTH + 1);

    state_t              state, state_next;
    logic                pend, pend_next;
    logic [31:0]         pend_pc, pend_pc_next;
    logic [FCNT_W-1:0]   fcnt, fcnt_next;
    logic                redir, take, hold, run_mode, flush_inc;
    logic [31:0]         take_pc;

    assign redir = BRANCH_MASK[branch_jump];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pend    <= 1'b0;
            pend_pc <= '0;
            fcnt    <= '0;
        end else begin
            state   <= state_next;
            pend    <= pend_next;
            pend_pc <= pend_pc_next;
            fcnt    <= fcnt_next;
        end
    end

    // NOTE: every signal driven here gets a default before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        pend_next    = pend;
        pend_pc_next = pend_pc;
        fcnt_next    = fcnt;
        take         = 1'b0;
        take_pc      = redirect_pc;
        hold         = 1'b0;
        run_mode     = 1'b0;
        flush_inc    = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        pc_target    = '0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_hold    = 1'b0;

        unique case (state)
            FLUSH: begin
                if (dmem_busy) begin
                    hold = 1'b1;
                end else if (redir) begin
                    take = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_flush = 1'b1;
                    fcnt_next   = fcnt - FCNT_W'(1);
                    if (fcnt == FCNT_W'(1)) state_next = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    hold = 1'b1;
                    // The first redirect seen while frozen is the oldest; keep it.
                    if (redir && !pend) begin
                        pend_next    = 1'b1;
                        pend_pc_next = redirect_pc;
                    end
                end else if (pend) begin
                    take      = 1'b1;
                    take_pc   = pend_pc;
                    pend_next = 1'b0;
                end else begin
                    run_mode = 1'b1;
                end
            end
            default: run_mode = 1'b1;
        endcase

        // FETCH_WAIT decodes exactly like RUN; only the idle case differs.
        if (run_mode) begin
            if (dmem_busy) begin
                hold       = 1'b1;
                state_next = MEM_WAIT;
                if (redir) begin
                    pend_next    = 1'b1;
                    pend_pc_next = redirect_pc;
                end
            end else if (redir) begin
                take = 1'b1;
            end else if (load_use) begin
                id_ex_flush = 1'b1;
                state_next  = RUN;
            end else if (!imem_ready) begin
                if_id_flush = 1'b1;
                state_next  = FETCH_WAIT;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                state_next  = RUN;
            end
        end

        pipe_hold = hold;

        if (take) begin
            pc_sel      = 1'b1;
            pc_target   = take_pc;
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                fcnt_next  = FCNT_W'(FLUSH_DEPTH - 1);
                state_next = FLUSH;
            end else begin
                state_next = RUN;
            end
        end

        // Controls read as all-zero while reset is asserted.
        if (!rst_n) begin
            pc_write    = 1'b0;
            pc_sel      = 1'b0;
            pc_target   = '0;
            if_id_write = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            pipe_hold   = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_sequencer.sv
// Bench for pipe_sequencer: two instances (FLUSH_DEPTH=1/CNT_W=16 and
// FLUSH_DEPTH=3/CNT_W=4) driven in lockstep against an event-level model.
module tb_pipe_sequencer;

    typedef struct packed {
        logic        pc_write;
        logic        pc_sel;
        logic [31:0] pc_target;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        pipe_hold;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  branch_jump = '0;
    logic [31:0] redirect_pc = '0;
    logic        load_use = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dmem_busy = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        pcw_a, pcs_a, ifw_a, iff_a, ief_a, ph_a;
    logic [31:0] pct_a;
    logic [15:0] stall_a, flush_a;
    logic        pcw_b, pcs_b, ifw_b, iff_b, ief_b, ph_b;
    logic [31:0] pct_b;
    logic [3:0]  stall_b, flush_b;

    always #5 clk = ~clk;

    pipe_sequencer #(.FLUSH_DEPTH(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .branch_jump(branch_jump), .redirect_pc(redirect_pc),
        .load_use(load_use), .imem_ready(imem_ready), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
        .pc_write(pcw_a), .pc_sel(pcs_a), .pc_target(pct_a), .if_id_write(ifw_a),
        .if_id_flush(iff_a), .id_ex_flush(ief_a), .pipe_hold(ph_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_sequencer #(.FLUSH_DEPTH(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .branch_jump(branch_jump), .redirect_pc(redirect_pc),
        .load_use(load_use), .imem_ready(imem_ready), .dmem_busy(dmem_busy), .cnt_clr(cnt_clr),
        .pc_write(pcw_b), .pc_sel(pcs_b), .pc_target(pct_b), .if_id_write(ifw_b),
        .if_id_flush(iff_b), .id_ex_flush(ief_b), .pipe_hold(ph_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b)
    );

    ctl_t act[2];
    int   act_stall[2];
    int   act_flush[2];
    always_comb begin
        act[0]       = '{pcw_a, pcs_a, pct_a, ifw_a, iff_a, ief_a, ph_a};
        act[1]       = '{pcw_b, pcs_b, pct_b, ifw_b, iff_b, ief_b, ph_b};
        act_stall[0] = int'(stall_a);
        act_stall[1] = int'(stall_b);
        act_flush[0] = int'(flush_a);
        act_flush[1] = int'(flush_b);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Event-level reference: remaining bubble cycles, a memory-freeze flag,
    // one parked redirect, and two saturating event tallies.
    logic [7:0]  mask = 8'b0000_1110;
    int          depth[2] = '{1, 3};
    int          cmax[2]  = '{65535, 15};
    int          bubbles[2], n_bubbles[2];
    bit          frozen[2], n_frozen[2];
    bit          parked[2], n_parked[2];
    logic [31:0] park_pc[2], n_park_pc[2];
    int          stalls[2], flushes[2];
    bit          stall_evt[2], flush_evt[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            bubbles[k] = 0; frozen[k] = 0; parked[k] = 0; park_pc[k] = '0;
            stalls[k] = 0; flushes[k] = 0;
        end
    endtask

    task automatic model_eval(input int k, output ctl_t e);
        bit          redir;
        bit          take;
        logic [31:0] tgt;
        redir = mask[branch_jump];
        take  = 0;
        tgt   = redirect_pc;
        e     = '0;
        n_bubbles[k] = bubbles[k]; n_frozen[k] = frozen[k];
        n_parked[k]  = parked[k];  n_park_pc[k] = park_pc[k];
        if (bubbles[k] > 0) begin
            if (dmem_busy) e.pipe_hold = 1;
            else if (redir) take = 1;
            else begin
                e.pc_write = 1; e.if_id_flush = 1;
                n_bubbles[k] = bubbles[k] - 1;
            end
        end else if (frozen[k] && dmem_busy) begin
            e.pipe_hold = 1;
            if (redir && !parked[k]) begin n_parked[k] = 1; n_park_pc[k] = redirect_pc; end
        end else if (frozen[k] && parked[k]) begin
            take = 1; tgt = park_pc[k]; n_parked[k] = 0;
        end else begin
            n_frozen[k] = 0;
            if (dmem_busy) begin
                e.pipe_hold = 1; n_frozen[k] = 1;
                if (redir) begin n_parked[k] = 1; n_park_pc[k] = redirect_pc; end
            end else if (redir) take = 1;
            else if (load_use) e.id_ex_flush = 1;
            else if (!imem_ready) e.if_id_flush = 1;
            else begin e.pc_write = 1; e.if_id_write = 1; end
        end
        if (take) begin
            e.pc_sel = 1; e.pc_target = tgt; e.pc_write = 1;
            e.if_id_flush = 1; e.id_ex_flush = 1;
            n_bubbles[k] = depth[k] - 1;
            n_frozen[k]  = 0;
        end
        flush_evt[k] = take;
        stall_evt[k] = !e.pc_write;
    endtask

    task automatic model_commit(input int k);
        bubbles[k] = n_bubbles[k]; frozen[k] = n_frozen[k];
        parked[k]  = n_parked[k];  park_pc[k] = n_park_pc[k];
        if (cnt_clr) begin
            stalls[k] = 0; flushes[k] = 0;
        end else begin
            if (stall_evt[k]) stalls[k]  = (stalls[k]  < cmax[k]) ? stalls[k] + 1  : cmax[k];
            if (flush_evt[k]) flushes[k] = (flushes[k] < cmax[k]) ? flushes[k] + 1 : cmax[k];
        end
    endtask

    // One clock: drive at negedge, compare controls, then compare counters after the edge.
    task automatic step(input logic [2:0] bj, input logic [31:0] pc, input logic lu,
                        input logic imr, input logic busy, input logic clr);
        ctl_t e;
        branch_jump = bj; redirect_pc = pc; load_use = lu;
        imem_ready = imr; dmem_busy = busy; cnt_clr = clr;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k, e);
            check($sformatf("ctl[%0d]", k), 64'(act[k]), 64'(e));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_commit(k);
            check($sformatf("stall_cnt[%0d]", k), 64'(act_stall[k]), 64'(stalls[k]));
            check($sformatf("flush_cnt[%0d]", k), 64'(act_flush[k]), 64'(flushes[k]));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ctl[%0d]", k), 64'(act[k]), 64'd0);
            check($sformatf("rst_stall[%0d]", k), 64'(act_stall[k]), 64'd0);
            check($sformatf("rst_flush[%0d]", k), 64'(act_flush[k]), 64'd0);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Taken branch in RUN redirects in the same cycle.
        step(3'd1, 32'h40, 0, 1, 0, 0);
        check("t1_flush_cnt", 64'(flush_a), 64'd1);
        step(3'd0, 32'h0, 0, 1, 0, 0);

        // Load-use inserts a single bubble.
        do_reset();
        step(3'd0, 32'h0, 1, 1, 0, 0);
        check("t2_stall_cnt", 64'(stall_a), 64'd1);
        step(3'd0, 32'h0, 0, 1, 0, 0);
        check("t2_no_more_stall", 64'(stall_a), 64'd1);

        // Memory freeze with a redirect parked in its first cycle.
        do_reset();
        step(3'd2, 32'h80, 0, 1, 1, 0);
        step(3'd0, 32'h0, 0, 1, 1, 0);
        step(3'd0, 32'h0, 0, 1, 1, 0);
        check("t3_stall_cnt", 64'(stall_a), 64'd3);
        step(3'd0, 32'h0, 0, 1, 0, 0);
        check("t3_flush_cnt", 64'(flush_a), 64'd1);

        // Deep flush on dut_b: redirect plus two FLUSH cycles, then RUN.
        do_reset();
        step(3'd3, 32'h1000, 0, 1, 0, 0);
        step(3'd0, 32'h0, 0, 1, 0, 0);
        step(3'd0, 32'h0, 0, 1, 0, 0);
        step(3'd0, 32'h0, 0, 1, 0, 0);
        check("t4_flush_cnt_b", 64'(flush_b), 64'd1);

        // Fetch wait, then a redirect arriving while still waiting.
        do_reset();
        step(3'd0, 32'h0, 0, 0, 0, 0);
        step(3'd0, 32'h0, 0, 0, 0, 0);
        step(3'd1, 32'h100, 0, 0, 0, 0);
        check("t5_stall_cnt", 64'(stall_a), 64'd2);

        // Counter saturation on the 4-bit instance, then clear.
        do_reset();
        for (int i = 0; i < 20; i++) step(3'd0, 32'h0, 1, 1, 0, 0);
        check("t6_stall_sat_b", 64'(stall_b), 64'd15);
        check("t6_stall_a", 64'(stall_a), 64'd20);
        for (int i = 0; i < 18; i++) step(3'd2, 32'h200 + 32'(i), 0, 1, 0, 0);
        check("t6_flush_sat_b", 64'(flush_b), 64'd15);
        step(3'd0, 32'h0, 1, 1, 0, 1);
        check("t6_clr_b", 64'(stall_b), 64'd0);

        // Reset in the middle of a memory freeze drops the parked redirect.
        do_reset();
        step(3'd2, 32'h80, 0, 1, 1, 0);
        step(3'd0, 32'h0, 0, 1, 1, 0);
        do_reset();
        step(3'd0, 32'h0, 0, 1, 0, 0);
        check("t6_no_redirect", 64'(flush_a), 64'd0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  bj;
            logic [31:0] pc;
            bj = ($urandom_range(99) < 30) ? 3'($urandom_range(7)) : 3'd0;
            pc = $urandom;
            if ($urandom_range(299) == 0) do_reset();
            step(bj, pc, ($urandom_range(99) < 15), ($urandom_range(99) < 85),
                 ($urandom_range(99) < 20), ($urandom_range(99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
